spi_master_arbiter: RTL



---
 rtl/spi_master_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin SPI mode-0 master sharing one bus between NREQ requesters, one 8-bit full-duplex transfer per grant.
// Latency: grant one cycle after req seen in IDLE; done pulses 18*CLK_DIV cycles after grant; next grant CS_GAP cycles later.
// Backpressure: req is a level held by the requester; it is sampled only when the bus is free and ignored mid-transfer.
module spi_master_arbiter #(
    parameter int NREQ    = 2,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] tx_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rx_data,
    output logic              busy,
    output logic              CS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [6:0]      tx_shift;
    logic [7:0]      rx_shift;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;

    // FSM strobes
    logic            load;
    logic            tick;
    logic            finish;
    logic            div_end;
    logic            gap_end;

    // Arbitration results
    logic            any_req;
    logic            found;
    logic [PW:0]     arb_sum;
    logic [PW-1:0]   arb_cand;
    logic [PW-1:0]   arb_idx;
    logic [NREQ-1:0] arb_onehot;
    logic [7:0]      sel_tx;

    assign busy    = (state != IDLE);
    assign any_req = |req;
    assign div_end = (cnt == CW'(CLK_DIV - 1));
    assign gap_end = (cnt == CW'(CS_GAP - 1));

    // Round-robin pick: first set req at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        found      = 1'b0;
        arb_sum    = '0;
        arb_cand   = '0;
        arb_idx    = '0;
        arb_onehot = '0;
        sel_tx     = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            arb_sum = {1'b0, rr_ptr} + (PW + 1)'(i);
            if (arb_sum >= (PW + 1)'(NREQ)) begin
                arb_sum = arb_sum - (PW + 1)'(NREQ);
            end
            arb_cand = arb_sum[PW-1:0];
            if (!found && req[arb_cand]) begin
                found   = 1'b1;
                arb_idx = arb_cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == arb_idx) begin
                arb_onehot[i] = 1'b1;
                sel_tx        = tx_data[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle strobes; the last GAP cycle arbitrates so the next grant lands right after the gap
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        tick      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load      = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (div_end) begin
                    tick = 1'b1;
                    if (SCLK && bit_cnt == 3'd7) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (div_end) begin
                    finish    = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_end) begin
                    if (any_req) begin
                        load      = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: counters, shift registers, bus pins, grant/done and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bit_cnt  <= 3'd0;
            tx_shift <= 7'd0;
            rx_shift <= 8'h00;
            rr_ptr   <= '0;
            owner    <= '0;
            grant    <= '0;
            done     <= '0;
            rx_data  <= 8'h00;
            CS_n     <= 1'b1;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
        end else begin
            done <= '0;

            if (state == IDLE || tick || state_nxt != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (load) begin
                grant    <= arb_onehot;
                owner    <= arb_idx;
                CS_n     <= 1'b0;
                SCLK     <= 1'b0;
                MOSI     <= sel_tx[7];
                tx_shift <= sel_tx[6:0];
                bit_cnt  <= 3'd0;
            end

            if (tick) begin
                SCLK <= ~SCLK;
                if (!SCLK) begin
                    rx_shift <= {rx_shift[6:0], MISO};
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        MOSI <= 1'b0;
                    end else begin
                        MOSI     <= tx_shift[6];
                        tx_shift <= {tx_shift[5:0], 1'b0};
                    end
                end
            end

            if (finish) begin
                CS_n    <= 1'b1;
                rx_data <= rx_shift;
                done    <= grant;
                grant   <= '0;
                rr_ptr  <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
            end
        end
    end

endmodule
